// File: rtl/instruction_fetch_queue_pkg.sv
// ============================================================================
//  instruction_fetch_queue_pkg
//  Shared constants and types for the instruction fetch queue.
//  Revision: 1.0
// ============================================================================
`include "Header_File.svh"
`default_nettype none

package instruction_fetch_queue_pkg;

  localparam int WIDTH = `WIDTH;

  // Default queue depth (entries) and post-reset fetch address.
  localparam int              FQ_DEPTH = 4;
  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000);

  // Byte distance between the two words fetched in one cycle.
  localparam logic [WIDTH-1:0] C_WORD_BYTES = WIDTH'(4);
  // Fetch address advance for a full dual-word enqueue.
  localparam logic [WIDTH-1:0] C_PAIR_BYTES = WIDTH'(8);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

  // Force a target address onto a word boundary.
  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/Header_File.svh
// ============================================================================
//  Header_File.svh
//  Shared datapath width for the instruction fetch block.
//  Revision: 1.0
// ============================================================================
`ifndef HEADER_FILE_SVH
`define HEADER_FILE_SVH

`define WIDTH 32

`endif

// File: rtl/fetch_queue_fifo.sv
// ============================================================================
//  fetch_queue_fifo
//  Dual-push / dual-pop circular buffer of fetch entries. Pushes always
//  write two entries; pops are in-order (slot 1 only together with slot 0).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush_i,
  input  logic                                      push_i,
  input  instruction_fetch_queue_pkg::fetch_entry_t push_entry0_i,
  input  instruction_fetch_queue_pkg::fetch_entry_t push_entry1_i,
  input  logic                                      ready0_i,
  input  logic                                      ready1_i,
  output logic                                      valid0_o,
  output logic                                      valid1_o,
  output instruction_fetch_queue_pkg::fetch_entry_t head_entry0_o,
  output instruction_fetch_queue_pkg::fetch_entry_t head_entry1_o,
  output logic [$clog2(DEPTH):0]                    count_o
);

  import instruction_fetch_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic             w_pop0;
  logic             w_pop1;
  logic [CNT_W-1:0] w_pop_num;
  logic [CNT_W-1:0] w_push_num;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_head_nxt = head_q + PTR_W'(1);
  assign w_tail_nxt = tail_q + PTR_W'(1);

  assign valid0_o = (count_q >= CNT_W'(1));
  assign valid1_o = (count_q >= CNT_W'(2));

  // Slot 1 can only leave the queue behind slot 0.
  assign w_pop0 = valid0_o & ready0_i;
  assign w_pop1 = w_pop0 & valid1_o & ready1_i;

  assign w_pop_num  = CNT_W'(w_pop0) + CNT_W'(w_pop1);
  assign w_push_num = push_i ? CNT_W'(2) : CNT_W'(0);

  // Decode outputs are read straight out of storage.
  assign head_entry0_o = mem_q[head_q];
  assign head_entry1_o = mem_q[w_head_nxt];
  assign count_o       = count_q;

  // Next pointer/count; a flush discards everything including this cycle's pops.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(w_pop_num);
      if (push_i) begin
        tail_d = tail_q + PTR_W'(2);
      end
      count_d = count_q + w_push_num - w_pop_num;
    end
  end

  // Pointer and occupancy state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally not reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q]     <= push_entry0_i;
      mem_q[w_tail_nxt] <= push_entry1_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
// ============================================================================
//  instruction_fetch_queue
//  Dual-issue fetch front end: holds the fetch PC, drives two instruction
//  memory ports, and queues returned words for decode. Redirect flushes the
//  queue and reloads the PC; stall freezes fetch but not dequeue.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_queue #(
  parameter int FQ_DEPTH = instruction_fetch_queue_pkg::FQ_DEPTH,
  parameter logic [instruction_fetch_queue_pkg::WIDTH-1:0] RESET_PC =
    instruction_fetch_queue_pkg::RESET_PC
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Program_counter_IF_Pipeline_0,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Program_counter_IF_Pipeline_1,
  input  logic [instruction_fetch_queue_pkg::WIDTH-1:0] Instruction_IM_Pipeline_0,
  input  logic [instruction_fetch_queue_pkg::WIDTH-1:0] Instruction_IM_Pipeline_1,
  input  logic                                        Fetch_stall,
  input  logic                                        Redirect_valid,
  input  logic [instruction_fetch_queue_pkg::WIDTH-1:0] Redirect_pc,
  input  logic                                        Decode_ready_0,
  input  logic                                        Decode_ready_1,
  output logic                                        Valid_IF_Pipeline_0,
  output logic                                        Valid_IF_Pipeline_1,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Instruction_IF_Pipeline_0,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Instruction_IF_Pipeline_1,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Pc_IF_Pipeline_0,
  output logic [instruction_fetch_queue_pkg::WIDTH-1:0] Pc_IF_Pipeline_1
);

  import instruction_fetch_queue_pkg::*;

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] w_fetch_pc_p4;
  logic [CNT_W-1:0] w_count;
  logic             w_enq;
  fetch_entry_t     w_push0, w_push1;
  fetch_entry_t     w_head0, w_head1;

  assign w_fetch_pc_p4 = fetch_pc_q + C_WORD_BYTES;

  assign Program_counter_IF_Pipeline_0 = fetch_pc_q;
  assign Program_counter_IF_Pipeline_1 = w_fetch_pc_p4;

  // Room for a full pair is judged on the registered count only, so a
  // same-cycle dequeue never opens space early.
  assign w_enq = (w_count <= CNT_W'(FQ_DEPTH - 2)) && !Fetch_stall && !Redirect_valid;

  assign w_push0 = '{pc: fetch_pc_q,    instr: Instruction_IM_Pipeline_0};
  assign w_push1 = '{pc: w_fetch_pc_p4, instr: Instruction_IM_Pipeline_1};

  // Next fetch PC: redirect wins over everything, otherwise advance on enqueue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (Redirect_valid) begin
      fetch_pc_d = word_align(Redirect_pc);
    end else if (w_enq) begin
      fetch_pc_d = fetch_pc_q + C_PAIR_BYTES;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (Redirect_valid),
    .push_i        (w_enq),
    .push_entry0_i (w_push0),
    .push_entry1_i (w_push1),
    .ready0_i      (Decode_ready_0),
    .ready1_i      (Decode_ready_1),
    .valid0_o      (Valid_IF_Pipeline_0),
    .valid1_o      (Valid_IF_Pipeline_1),
    .head_entry0_o (w_head0),
    .head_entry1_o (w_head1),
    .count_o       (w_count)
  );

  assign Instruction_IF_Pipeline_0 = w_head0.instr;
  assign Instruction_IF_Pipeline_1 = w_head1.instr;
  assign Pc_IF_Pipeline_0          = w_head0.pc;
  assign Pc_IF_Pipeline_1          = w_head1.pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ============================================================================
//  tb_instruction_fetch_queue
//  Directed self-checking bench for instruction_fetch_queue (FQ_DEPTH=4).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc0, pc1;
  logic [31:0] im0, im1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        rdy0 = 1'b0;
  logic        rdy1 = 1'b0;
  logic        v0, v1;
  logic [31:0] ins0, ins1;
  logic [31:0] hpc0, hpc1;

  int checks = 0;
  int failures = 0;

  // Instruction memory model: word content encodes its own address.
  assign im0 = 32'hA000_0000 | pc0;
  assign im1 = 32'hA000_0000 | pc1;

  always #5 clk = ~clk;

  instruction_fetch_queue dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .Program_counter_IF_Pipeline_0 (pc0),
    .Program_counter_IF_Pipeline_1 (pc1),
    .Instruction_IM_Pipeline_0     (im0),
    .Instruction_IM_Pipeline_1     (im1),
    .Fetch_stall                   (stall),
    .Redirect_valid                (redir),
    .Redirect_pc                   (redir_pc),
    .Decode_ready_0                (rdy0),
    .Decode_ready_1                (rdy1),
    .Valid_IF_Pipeline_0           (v0),
    .Valid_IF_Pipeline_1           (v1),
    .Instruction_IF_Pipeline_0     (ins0),
    .Instruction_IF_Pipeline_1     (ins1),
    .Pc_IF_Pipeline_0              (hpc0),
    .Pc_IF_Pipeline_1              (hpc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vld();
    return {30'h0, v1, v0};
  endfunction

  function automatic logic [31:0] cnt();
    return 32'(dut.u_fifo.count_q);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;

    // Reset held for a couple of edges.
    step();
    step();
    chk("rst_valid", vld(), 32'h0);
    chk("rst_pc0",   pc0,   32'h0);
    chk("rst_pc1",   pc1,   32'h4);
    chk("rst_cnt",   cnt(), 32'h0);
    rst_n = 1'b1;

    // First edge after release enqueues RESET_PC / RESET_PC+4.
    step();
    chk("e1_valid", vld(), 32'h3);
    chk("e1_hpc0",  hpc0,  32'h0);
    chk("e1_hpc1",  hpc1,  32'h4);
    chk("e1_ins0",  ins0,  32'hA000_0000);
    chk("e1_ins1",  ins1,  32'hA000_0004);
    chk("e1_fpc",   pc0,   32'h8);

    // Fill to full, then PC freezes.
    step();
    chk("e2_cnt", cnt(), 32'h4);
    chk("e2_fpc", pc0,   32'h10);
    step();
    chk("full_cnt",  cnt(), 32'h4);
    chk("full_fpc0", pc0,   32'h10);
    chk("full_fpc1", pc1,   32'h14);
    chk("full_hpc0", hpc0,  32'h0);

    // Single pop while full: no enqueue.
    rdy0 = 1'b1; rdy1 = 1'b0;
    step();
    chk("p1_cnt",  cnt(), 32'h3);
    chk("p1_hpc0", hpc0,  32'h4);
    chk("p1_hpc1", hpc1,  32'h8);
    chk("p1_fpc",  pc0,   32'h10);

    // Dual pop at count 3: still no enqueue.
    rdy0 = 1'b1; rdy1 = 1'b1;
    step();
    chk("p2_cnt",   cnt(), 32'h1);
    chk("p2_valid", vld(), 32'h1);
    chk("p2_hpc0",  hpc0,  32'hC);
    chk("p2_fpc",   pc0,   32'h10);

    // Enqueue resumes.
    rdy0 = 1'b0; rdy1 = 1'b0;
    step();
    chk("r_cnt",  cnt(), 32'h3);
    chk("r_hpc1", hpc1,  32'h10);
    chk("r_ins1", ins1,  32'hA000_0010);
    chk("r_fpc",  pc0,   32'h18);

    // Slot 1 ready without slot 0: no pop.
    rdy0 = 1'b0; rdy1 = 1'b1;
    step();
    chk("r10_cnt",  cnt(), 32'h3);
    chk("r10_hpc0", hpc0,  32'hC);

    // Redirect with stall and pops requested: flush, aligned PC.
    stall = 1'b1; redir = 1'b1; redir_pc = 32'h103; rdy0 = 1'b1; rdy1 = 1'b1;
    step();
    chk("rd_valid", vld(), 32'h0);
    chk("rd_fpc",   pc0,   32'h100);
    chk("rd_cnt",   cnt(), 32'h0);
    stall = 1'b0; redir = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    step();
    chk("rd2_hpc0",  hpc0,  32'h100);
    chk("rd2_valid", vld(), 32'h3);
    chk("rd2_fpc",   pc0,   32'h108);

    // Stall holds PC, dequeue continues.
    stall = 1'b1; rdy0 = 1'b1;
    step();
    chk("st_fpc",   pc0,   32'h108);
    chk("st_valid", vld(), 32'h1);
    chk("st_hpc0",  hpc0,  32'h104);

    // Asynchronous reset mid-operation, no clock edge needed.
    stall = 1'b0; rdy0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", vld(), 32'h0);
    chk("ar_fpc",   pc0,   32'h0);
    chk("ar_cnt",   cnt(), 32'h0);
    rst_n = 1'b1;

    // Streaming with both slots ready: scoreboard expects 0x0..0x2C in order.
    rdy0 = 1'b1; rdy1 = 1'b1;
    exp_pc = 32'h0;
    for (int cyc = 0; cyc < 24 && exp_pc < 32'h30; cyc++) begin
      if (v0) begin
        chk("sb_pc0",  hpc0, exp_pc);
        chk("sb_ins0", ins0, 32'hA000_0000 | exp_pc);
        exp_pc = exp_pc + 32'h4;
        if (v1) begin
          chk("sb_pc1",  hpc1, exp_pc);
          chk("sb_ins1", ins1, 32'hA000_0000 | exp_pc);
          exp_pc = exp_pc + 32'h4;
        end
      end
      step();
    end
    chk("sb_total", exp_pc, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
